// File: rtl/peripheral_bus_arbiter.sv
// Two-master round-robin arbiter for the shared peripheral bus.
// A grant is held for the whole transfer. The losing master is stalled by
// holding its busy high.
// Optional watchdog: define PERIPHERAL_BUS_TIMEOUT_EN to force-terminate
// transfers on which the peripheral holds busy for TIMEOUT_CYCLES cycles.
module peripheral_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_peripheralBus_we,
  input  logic        m0_peripheralBus_oe,
  input  logic [23:0] m0_peripheralBus_address,
  input  logic [3:0]  m0_peripheralBus_byteSelect,
  input  logic [31:0] m0_peripheralBus_dataWrite,
  output logic        m0_peripheralBus_busy,
  output logic [31:0] m0_peripheralBus_dataRead,
  input  logic        m1_peripheralBus_we,
  input  logic        m1_peripheralBus_oe,
  input  logic [23:0] m1_peripheralBus_address,
  input  logic [3:0]  m1_peripheralBus_byteSelect,
  input  logic [31:0] m1_peripheralBus_dataWrite,
  output logic        m1_peripheralBus_busy,
  output logic [31:0] m1_peripheralBus_dataRead,
  output logic        peripheralBus_we,
  output logic        peripheralBus_oe,
  output logic [23:0] peripheralBus_address,
  output logic [3:0]  peripheralBus_byteSelect,
  output logic [31:0] peripheralBus_dataWrite,
  input  logic        peripheralBus_busy,
  input  logic [31:0] peripheralBus_dataRead,
  output logic        timeout_o
);

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TIMEOUT} state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
`endif

  state_t state, next_state;
  logic   last_grant, next_last_grant;
  logic   req0, req1;

  assign req0 = m0_peripheralBus_we | m0_peripheralBus_oe;
  assign req1 = m1_peripheralBus_we | m1_peripheralBus_oe;

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_count;
  logic        wd_expire;
  logic        timeout_q;

  // The transfer expires on the busy cycle that would bring the count to TIMEOUT_CYCLES.
  assign wd_expire = ((state == GRANT0) || (state == GRANT1)) &&
                     peripheralBus_busy && (wd_count == WD_LAST);
  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;

  // Without the watchdog the timeout length has no meaning, and the pulse never fires.
  assign unused_timeout_cfg = |16'(TIMEOUT_CYCLES);
  assign timeout_o = 1'b0;
`endif

  // Arbitration: the next owner of the bus and the round-robin pointer.
  always_comb begin
    next_state      = state;
    next_last_grant = last_grant;
    case (state)
      IDLE: begin
        if (req0 && req1) next_state = last_grant ? GRANT0 : GRANT1;
        else if (req0)    next_state = GRANT0;
        else if (req1)    next_state = GRANT1;
      end
      GRANT0: if (!req0) next_state = req1 ? GRANT1 : IDLE;
      GRANT1: if (!req1) next_state = req0 ? GRANT0 : IDLE;
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
      TIMEOUT: begin
        if (last_grant && !req1)       next_state = req0 ? GRANT0 : IDLE;
        else if (!last_grant && !req0) next_state = req1 ? GRANT1 : IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
    if (wd_expire) next_state = TIMEOUT;
`endif
    if ((next_state == GRANT0) && (state != GRANT0)) next_last_grant = 1'b0;
    if ((next_state == GRANT1) && (state != GRANT1)) next_last_grant = 1'b1;
  end

  // State register and round-robin pointer. The pointer resets to 1 so master 0 wins the first tie.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
    end
  end

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
  // Watchdog: count consecutive busy cycles of a held grant and register the one-cycle pulse.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd_count  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_expire;
      if (((state == GRANT0) || (state == GRANT1)) && (next_state == state) && peripheralBus_busy)
        wd_count <= wd_count + 16'd1;
      else
        wd_count <= 16'd0;
    end
  end
`endif

  // Routing: only the granted master reaches the shared bus. Everyone else is stalled.
  always_comb begin
    peripheralBus_we          = 1'b0;
    peripheralBus_oe          = 1'b0;
    peripheralBus_address     = 24'd0;
    peripheralBus_byteSelect  = 4'd0;
    peripheralBus_dataWrite   = 32'd0;
    m0_peripheralBus_busy     = 1'b1;
    m1_peripheralBus_busy     = 1'b1;
    m0_peripheralBus_dataRead = 32'hFFFF_FFFF;
    m1_peripheralBus_dataRead = 32'hFFFF_FFFF;
    case (state)
      GRANT0: begin
        peripheralBus_we          = m0_peripheralBus_we;
        peripheralBus_oe          = m0_peripheralBus_oe;
        peripheralBus_address     = m0_peripheralBus_address;
        peripheralBus_byteSelect  = m0_peripheralBus_byteSelect;
        peripheralBus_dataWrite   = m0_peripheralBus_dataWrite;
        m0_peripheralBus_busy     = peripheralBus_busy;
        m0_peripheralBus_dataRead = peripheralBus_dataRead;
      end
      GRANT1: begin
        peripheralBus_we          = m1_peripheralBus_we;
        peripheralBus_oe          = m1_peripheralBus_oe;
        peripheralBus_address     = m1_peripheralBus_address;
        peripheralBus_byteSelect  = m1_peripheralBus_byteSelect;
        peripheralBus_dataWrite   = m1_peripheralBus_dataWrite;
        m1_peripheralBus_busy     = peripheralBus_busy;
        m1_peripheralBus_dataRead = peripheralBus_dataRead;
      end
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
      TIMEOUT: begin
        if (last_grant) m1_peripheralBus_busy = 1'b0;
        else            m0_peripheralBus_busy = 1'b0;
      end
`endif
      default: ;
    endcase
  end

endmodule
